// File: rtl/resp_packetizer_target.sv
// NoC target-side response packetizer: routes each core response via the LUT and
// emits a header flit followed by body/tail flits, dropping unroutable responses.
module resp_packetizer_target #(
    parameter int unsigned          FLITWD   = 80,
    parameter int unsigned          SOURCEWD = 4,
    parameter int unsigned          PATHWD   = 7,
    parameter int unsigned          DATAWD   = 32,
    parameter logic [SOURCEWD-1:0]  MY_ID    = 4'h0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                resp_valid,
    output logic                resp_ready,
    input  logic [SOURCEWD-1:0] resp_source,
    input  logic [DATAWD-1:0]   resp_data,
    input  logic                resp_last,
    output logic [SOURCEWD-1:0] lut_address,
    input  logic [PATHWD-1:0]   lut_path,
    output logic [FLITWD-1:0]   flit_out,
    output logic                flit_valid,
    input  logic                flit_stall,
    output logic                err_unroutable
);

    localparam int unsigned TYPE_MSB = FLITWD - 1;
    localparam int unsigned PATH_MSB = FLITWD - 3;
    localparam int unsigned ID_MSB   = FLITWD - 3 - PATHWD;

    localparam logic [1:0] TYPE_HEADER = 2'b10;
    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_TAIL   = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        HEADER,
        PAYLOAD,
        DROP
    } state_t;

    state_t                state_q, state_d;
    logic [SOURCEWD-1:0]   src_q, src_d;
    logic [FLITWD-1:0]     flit_q, flit_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;
    logic                  xfer;

    assign xfer = valid_q && !flit_stall;

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            flit_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Next-state, flit build and beat handshake
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        flit_d     = flit_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        last_d     = last_q;
        resp_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (resp_valid) begin
                    src_d   = resp_source;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lut_path != '0) begin
                    flit_d                         = '0;
                    flit_d[TYPE_MSB -: 2]          = TYPE_HEADER;
                    flit_d[PATH_MSB -: PATHWD]     = lut_path;
                    flit_d[ID_MSB -: SOURCEWD]     = MY_ID;
                    valid_d                        = 1'b1;
                    state_d                        = HEADER;
                end else begin
                    err_d   = 1'b1;
                    state_d = DROP;
                end
            end
            HEADER: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Once the tail is loaded, hold off further beats until it leaves
                resp_ready = !last_q && (!valid_q || !flit_stall);
                if (resp_ready && resp_valid) begin
                    flit_d                  = '0;
                    flit_d[TYPE_MSB -: 2]   = resp_last ? TYPE_TAIL : TYPE_BODY;
                    flit_d[DATAWD-1:0]      = resp_data;
                    valid_d                 = 1'b1;
                    last_d                  = resp_last;
                end else if (xfer) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                resp_ready = 1'b1;
                valid_d    = 1'b0;
                if (resp_valid && resp_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lut_address    = src_q;
    assign flit_out       = flit_q;
    assign flit_valid     = valid_q;
    assign err_unroutable = err_q;

endmodule
